// File: rtl/mem_lsu.sv
// Memory stage: passes ALU results through, or sequences byte/half/word loads
// and stores one byte per cycle over an 8-bit synchronous RAM port.
module mem_lsu #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_en_i,
   input  logic [3:0]        mem_op_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [31:0]       reg2_i,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   input  logic [31:0]       wdata_i,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic [31:0]       wdata_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              ram_ce_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_op;
   logic [31:0] r_addr;
   logic [31:0] r_reg2;
   logic [31:0] r_acc;
   logic [4:0]  r_wd;
   logic        r_wreg;
   logic [1:0]  r_k;

   logic        w_store;
   logic        w_signExt;
   logic [1:0]  w_last;
   logic [1:0]  w_kPrev;
   logic [31:0] w_byteAddr;
   logic [31:0] w_loadData;

   assign w_store    = r_op[3];
   assign w_signExt  = ~r_op[2];
   assign w_last     = (r_op[1:0] == 2'b00) ? 2'd0 : (r_op[1:0] == 2'b01) ? 2'd1 : 2'd3;
   assign w_kPrev    = r_k - 2'd1;
   assign w_byteAddr = r_addr + {30'd0, r_k};

   always_comb begin
      case (r_op[1:0])
         2'b00:   w_loadData = {{24{w_signExt & r_acc[7]}}, r_acc[7:0]};
         2'b01:   w_loadData = {{16{w_signExt & r_acc[15]}}, r_acc[15:0]};
         default: w_loadData = r_acc;
      endcase
   end

   // Read data lags its address by one cycle, so ACCESS step k stores byte k-1
   // and the trailing WAIT cycle picks up the final byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_op    <= 4'd0;
         r_addr  <= 32'd0;
         r_reg2  <= 32'd0;
         r_acc   <= 32'd0;
         r_wd    <= 5'd0;
         r_wreg  <= 1'b0;
         r_k     <= 2'd0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (mem_en_i) begin
                  r_op   <= mem_op_i;
                  r_addr <= mem_addr_i;
                  r_reg2 <= reg2_i;
                  r_wd   <= wd_i;
                  r_wreg <= wreg_i;
                  r_acc  <= 32'd0;
                  r_k    <= 2'd0;
               end
            end
            ACCESS: begin
               if (!w_store && (r_k != 2'd0))
                  r_acc[{w_kPrev, 3'b000} +: 8] <= ram_din_i;
               r_k <= r_k + 2'd1;
            end
            WAIT: r_acc[{w_last, 3'b000} +: 8] <= ram_din_i;
            default: ;
         endcase
      end
   end

   // Everything is forced low while reset is held, including the pass-through path.
   always_comb begin
      w_next     = r_state;
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      wdata_o    = 32'd0;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      ram_ce_o   = 1'b0;
      ram_we_o   = 1'b0;
      ram_addr_o = '0;
      ram_dout_o = 8'd0;
      case (r_state)
         IDLE: begin
            if (mem_en_i) begin
               busy_o = 1'b1;
               w_next = ACCESS;
            end else begin
               wd_o    = wd_i;
               wreg_o  = wreg_i;
               wdata_o = wdata_i;
            end
         end
         ACCESS: begin
            busy_o     = 1'b1;
            ram_ce_o   = 1'b1;
            ram_we_o   = w_store;
            ram_addr_o = w_byteAddr[ADDR_W-1:0];
            if (w_store)
               ram_dout_o = r_reg2[{r_k, 3'b000} +: 8];
            if (r_k == w_last)
               w_next = w_store ? DONE : WAIT;
         end
         WAIT: begin
            busy_o = 1'b1;
            w_next = DONE;
         end
         DONE: begin
            done_o = 1'b1;
            wd_o   = r_wd;
            if (!w_store) begin
               wreg_o  = r_wreg;
               wdata_o = w_loadData;
            end
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      if (rst) begin
         wd_o       = 5'd0;
         wreg_o     = 1'b0;
         wdata_o    = 32'd0;
         busy_o     = 1'b0;
         done_o     = 1'b0;
         ram_ce_o   = 1'b0;
         ram_we_o   = 1'b0;
         ram_addr_o = '0;
         ram_dout_o = 8'd0;
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: byte-wide RAM stand-in plus a byte-array reference
// memory from which expected RAM traffic and load results are computed.
module tb_mem_lsu;

   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              mem_en_i;
   logic [3:0]        mem_op_i;
   logic [31:0]       mem_addr_i;
   logic [31:0]       reg2_i;
   logic [4:0]        wd_i;
   logic              wreg_i;
   logic [31:0]       wdata_i;
   logic [4:0]        wd_o;
   logic              wreg_o;
   logic [31:0]       wdata_o;
   logic              busy_o;
   logic              done_o;
   logic              ram_ce_o;
   logic              ram_we_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [7:0]        ram_dout_o;
   logic [7:0]        ramRead;
   logic              ramClear;

   logic [7:0] ram [0:4095];
   bit   [7:0] refMem [0:4095];

   int checks = 0;
   int failures = 0;

   mem_lsu #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .mem_en_i(mem_en_i), .mem_op_i(mem_op_i),
      .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .wdata_i(wdata_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .busy_o(busy_o), .done_o(done_o), .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o),
      .ram_addr_o(ram_addr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ramRead)
   );

   always #5 clk = ~clk;

   // Synchronous byte RAM, 4 KiB aliased on the low address bits
   always @(posedge clk) begin
      if (ramClear) begin
         for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      end else if (ram_ce_o && ram_we_o) begin
         ram[ram_addr_o[11:0]] <= ram_dout_o;
      end
      if (ram_ce_o && !ram_we_o)
         ramRead <= ram[ram_addr_o[11:0]];
   end

   // One memory instruction: starts in IDLE (or in the previous DONE when b2b),
   // checks every cycle through DONE, and returns sampling inside DONE.
   task automatic doOp(input bit isStore, input bit isUns, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] wd, input bit wr, input bit b2b, input string tag);
      int n;
      logic [31:0] a;
      logic [31:0] expData;
      logic [11:0] idx;
      n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      if (!b2b) @(negedge clk);
      mem_en_i   = 1'b1;
      mem_op_i   = {isStore, isUns, size};
      mem_addr_i = addr;
      reg2_i     = data;
      wd_i       = wd;
      wreg_i     = wr;
      wdata_i    = $urandom;
      if (b2b) begin
         #1;
         checks++;
         if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s b2b_prev_done: done=%b busy=%b expected done=1 busy=0", tag, done_o, busy_o);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (busy_o !== 1'b1 || wd_o !== 5'd0 || wreg_o !== 1'b0 || wdata_o !== 32'd0 || ram_ce_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s accept: busy=%b wd=%0d wreg=%b wdata=%h ce=%b expected 1/0/0/0/0",
                  tag, busy_o, wd_o, wreg_o, wdata_o, ram_ce_o);
      end
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         #1;
         a = addr + k;
         checks++;
         if (ram_ce_o !== 1'b1 || ram_we_o !== isStore || ram_addr_o !== a || busy_o !== 1'b1 || done_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s access%0d: ce=%b we=%b addr=%h busy=%b done=%b expected 1/%b/%h/1/0",
                     tag, k, ram_ce_o, ram_we_o, ram_addr_o, busy_o, done_o, isStore, a);
         end
         if (isStore) begin
            checks++;
            if (ram_dout_o !== data[8*k +: 8]) begin
               failures++;
               $display("[TB] FAIL %s dout%0d: got %h expected %h", tag, k, ram_dout_o, data[8*k +: 8]);
            end
         end
      end
      if (!isStore) begin
         @(negedge clk);
         #1;
         checks++;
         if (ram_ce_o !== 1'b0 || ram_we_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s wait: ce=%b we=%b busy=%b done=%b expected 0/0/1/0",
                     tag, ram_ce_o, ram_we_o, busy_o, done_o);
         end
      end
      expData = 32'd0;
      for (int i = 0; i < n; i++) begin
         a = addr + i;
         idx = a[11:0];
         if (isStore) refMem[idx] = data[8*i +: 8];
         else expData = expData | ({24'd0, refMem[idx]} << (8*i));
      end
      if (!isStore && !isUns && n < 4 && expData[8*n-1])
         expData = expData | (32'hFFFF_FFFF << (8*n));
      @(negedge clk);
      #1;
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || ram_ce_o !== 1'b0 || wd_o !== wd ||
          wreg_o !== (isStore ? 1'b0 : wr) || wdata_o !== expData) begin
         failures++;
         $display("[TB] FAIL %s done: done=%b busy=%b ce=%b wd=%0d wreg=%b wdata=%h expected 1/0/0/%0d/%b/%h",
                  tag, done_o, busy_o, ram_ce_o, wd_o, wreg_o, wdata_o, wd, isStore ? 1'b0 : wr, expData);
      end
      mem_en_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ramClear = 1'b1;
      mem_en_i = 1'b1;
      mem_op_i = 4'b0010;
      mem_addr_i = 32'h40;
      reg2_i = 32'h1234_5678;
      wd_i = 5'd9;
      wreg_i = 1'b1;
      wdata_i = 32'hCAFE_F00D;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (wd_o !== 5'd0 || wreg_o !== 1'b0 || wdata_o !== 32'd0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
          ram_ce_o !== 1'b0 || ram_we_o !== 1'b0 || ram_addr_o !== '0 || ram_dout_o !== 8'd0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: wd=%0d wreg=%b wdata=%h busy=%b done=%b ce=%b we=%b expected all zero",
                  wd_o, wreg_o, wdata_o, busy_o, done_o, ram_ce_o, ram_we_o);
      end
      mem_en_i = 1'b0;
      ramClear = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_passthrough();
      logic [4:0] expWd;
      logic expWr;
      logic [31:0] expData;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         expWd   = (i == 0) ? 5'd5 : 5'($urandom);
         expWr   = (i == 0) ? 1'b1 : 1'($urandom);
         expData = (i == 0) ? 32'hDEAD_BEEF : $urandom;
         mem_en_i = 1'b0;
         wd_i = expWd;
         wreg_i = expWr;
         wdata_i = expData;
         #1;
         checks++;
         if (wd_o !== expWd || wreg_o !== expWr || wdata_o !== expData || busy_o !== 1'b0 ||
             done_o !== 1'b0 || ram_ce_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL passthrough%0d: wd=%0d wreg=%b wdata=%h busy=%b ce=%b expected %0d/%b/%h/0/0",
                     i, wd_o, wreg_o, wdata_o, busy_o, ram_ce_o, expWd, expWr, expData);
         end
      end
   endtask

   task automatic test_word();
      doOp(1'b1, 1'b0, 2'b10, 32'h100, 32'h1122_3344, 5'd3, 1'b1, 1'b0, "sw");
      checks++;
      if (ram[12'h100] !== 8'h44 || ram[12'h101] !== 8'h33 || ram[12'h102] !== 8'h22 || ram[12'h103] !== 8'h11) begin
         failures++;
         $display("[TB] FAIL sw_ram: got %h %h %h %h expected 44 33 22 11",
                  ram[12'h100], ram[12'h101], ram[12'h102], ram[12'h103]);
      end
      doOp(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 5'd7, 1'b1, 1'b0, "lw");
      checks++;
      if (wdata_o !== 32'h1122_3344) begin
         failures++;
         $display("[TB] FAIL lw_value: got %h expected 11223344", wdata_o);
      end
   endtask

   task automatic test_extension();
      doOp(1'b1, 1'b0, 2'b00, 32'h180, 32'h0000_0080, 5'd1, 1'b1, 1'b0, "sb80");
      doOp(1'b0, 1'b0, 2'b00, 32'h180, 32'h0, 5'd2, 1'b1, 1'b0, "lb");
      checks++;
      if (wdata_o !== 32'hFFFF_FF80) begin
         failures++;
         $display("[TB] FAIL lb_sign: got %h expected ffffff80", wdata_o);
      end
      doOp(1'b0, 1'b1, 2'b00, 32'h180, 32'h0, 5'd2, 1'b1, 1'b0, "lbu");
      checks++;
      if (wdata_o !== 32'h0000_0080) begin
         failures++;
         $display("[TB] FAIL lbu_zero: got %h expected 00000080", wdata_o);
      end
      doOp(1'b1, 1'b0, 2'b01, 32'h185, 32'h0000_F234, 5'd1, 1'b1, 1'b0, "shf234");
      doOp(1'b0, 1'b0, 2'b01, 32'h185, 32'h0, 5'd4, 1'b1, 1'b0, "lh");
      checks++;
      if (wdata_o !== 32'hFFFF_F234) begin
         failures++;
         $display("[TB] FAIL lh_sign: got %h expected fffff234", wdata_o);
      end
      doOp(1'b0, 1'b1, 2'b01, 32'h185, 32'h0, 5'd4, 1'b0, 1'b0, "lhu");
      checks++;
      if (wdata_o !== 32'h0000_F234 || wreg_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL lhu_zero: got %h wreg=%b expected 0000f234 wreg=0", wdata_o, wreg_o);
      end
   endtask

   task automatic test_wrap();
      doOp(1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0000_AABB, 5'd6, 1'b1, 1'b0, "sh_wrap");
      checks++;
      if (ram[12'hFFF] !== 8'hBB || ram[12'h000] !== 8'hAA) begin
         failures++;
         $display("[TB] FAIL wrap_ram: got %h %h expected bb aa", ram[12'hFFF], ram[12'h000]);
      end
      doOp(1'b0, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0, 5'd6, 1'b1, 1'b0, "lhu_wrap");
   endtask

   task automatic test_reset_midstore();
      logic [31:0] data;
      data = $urandom;
      @(negedge clk);
      mem_en_i = 1'b1;
      mem_op_i = 4'b1010;
      mem_addr_i = 32'h300;
      reg2_i = data;
      wd_i = 5'd8;
      wreg_i = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (ram_we_o !== 1'b1 || ram_addr_o !== 32'h301) begin
         failures++;
         $display("[TB] FAIL rst_pre: we=%b addr=%h expected 1/00000301", ram_we_o, ram_addr_o);
      end
      rst = 1'b1;
      mem_en_i = 1'b0;
      wdata_i = 32'h5A5A_5A5A;
      #1;
      checks++;
      if (ram_we_o !== 1'b0 || ram_ce_o !== 1'b0 || busy_o !== 1'b0 || wreg_o !== 1'b0 ||
          wdata_o !== 32'd0 || wd_o !== 5'd0) begin
         failures++;
         $display("[TB] FAIL rst_mid: we=%b ce=%b busy=%b wreg=%b wdata=%h wd=%0d expected all zero",
                  ram_we_o, ram_ce_o, busy_o, wreg_o, wdata_o, wd_o);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || wdata_o !== 32'h5A5A_5A5A || wd_o !== 5'd8) begin
         failures++;
         $display("[TB] FAIL rst_idle: busy=%b done=%b wdata=%h wd=%0d expected 0/0/5a5a5a5a/8",
                  busy_o, done_o, wdata_o, wd_o);
      end
      refMem[12'h300] = data[7:0];
      checks++;
      if (ram[12'h300] !== refMem[12'h300] || ram[12'h301] !== refMem[12'h301] ||
          ram[12'h302] !== refMem[12'h302] || ram[12'h303] !== refMem[12'h303]) begin
         failures++;
         $display("[TB] FAIL rst_ram: got %h %h %h %h expected %h %h %h %h",
                  ram[12'h300], ram[12'h301], ram[12'h302], ram[12'h303],
                  refMem[12'h300], refMem[12'h301], refMem[12'h302], refMem[12'h303]);
      end
   endtask

   task automatic test_back_to_back();
      doOp(1'b1, 1'b0, 2'b00, 32'h1C0, 32'h0000_00E7, 5'd10, 1'b1, 1'b0, "sb_b2b");
      doOp(1'b0, 1'b1, 2'b00, 32'h1C0, 32'h0, 5'd11, 1'b1, 1'b1, "lbu_b2b");
      checks++;
      if (wdata_o !== 32'h0000_00E7) begin
         failures++;
         $display("[TB] FAIL b2b_value: got %h expected 000000e7", wdata_o);
      end
   endtask

   task automatic test_random();
      logic [31:0] addr;
      for (int i = 0; i < 40; i++) begin
         addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                           : (32'h200 + 32'($urandom_range(0, 15)));
         doOp(1'($urandom), 1'($urandom), 2'($urandom), addr, $urandom, 5'($urandom), 1'($urandom),
              (i != 0) && ($urandom_range(0, 1) == 1), "rand");
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_word();
      test_extension();
      test_wrap();
      test_reset_midstore();
      test_back_to_back();
      test_random();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
